// File: rtl/cy_stream_packer_pkg.sv
// Shared helpers for the stream packer: counter width and keep-lane decode.
// Imported by cy_stream_packer and cy_idle_timer.
package cy_stream_packer_pkg;

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int cy_clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Keep-mask construction: lane is kept when it is one of the lowest 'lanes'.
    function automatic logic lane_kept(input int lane, input int lanes);
        return (lane < lanes);
    endfunction

endpackage

// File: rtl/cy_idle_timer.sv
// Saturating idle counter: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT-th consecutive enabled cycle.
module cy_idle_timer
    import cy_stream_packer_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam int TW = cy_clog2(TIMEOUT);
    localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST_COUNT)) begin
            r_count <= r_count + TW'(1);
        end
    end

    // Expiry is held while enabled, so a flush blocked by back-pressure waits.
    assign o_expire = i_en && (r_count == LAST_COUNT);

endmodule

// File: rtl/cy_stream_packer.sv
// Packs RATIO consecutive DW-bit beats into one registered DW*RATIO word with
// per-lane keep; i_last closes a word early. Idle auto-flush: CY_PACK_TIMEOUT_EN.
module cy_stream_packer
    import cy_stream_packer_pkg::*;
#(
    parameter int DW      = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DW-1:0]         i_data,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DW*RATIO-1:0]   o_data,
    output logic [RATIO-1:0]      o_keep,
    output logic                  o_last
);

    localparam int WW = DW * RATIO;
    localparam int CW = cy_clog2(RATIO);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    if (RATIO < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("cy_stream_packer: RATIO and TIMEOUT must be >= 1");
    end

    logic [CW-1:0]    r_cnt;
    logic [WW-1:0]    r_acc;
    logic [WW-1:0]    r_data;
    logic [RATIO-1:0] r_keep;
    logic             r_valid;
    logic             r_last;

    logic             w_accept;
    logic             w_close;
    logic             w_flush;
    logic [WW-1:0]    w_merged;
    logic [RATIO-1:0] w_keep_close;
    logic [RATIO-1:0] w_keep_flush;

    assign o_ready  = !r_valid || i_ready;
    assign w_accept = i_valid && o_ready;
    assign w_close  = w_accept && (i_last || (r_cnt == LAST_LANE));

    // Lanes above r_cnt are always zero in r_acc, so a closing merge zero-fills.
    // NOTE: every always_comb output gets a default before any conditional
    // update, which rules out inferred latches.
    always_comb begin
        w_merged     = r_acc;
        w_keep_close = '0;
        w_keep_flush = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) == r_cnt) begin
                w_merged[k*DW +: DW] = i_data;
            end
            w_keep_close[k] = lane_kept(k, int'(r_cnt) + 1);
            w_keep_flush[k] = lane_kept(k, int'(r_cnt));
        end
    end

`ifdef CY_PACK_TIMEOUT_EN
    logic w_idle_en;
    logic w_expire;

    assign w_idle_en = (r_cnt != '0) && !w_accept;

    cy_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (w_accept || w_flush),
        .i_en      (w_idle_en),
        .o_expire  (w_expire)
    );

    assign w_flush = w_expire && o_ready;
`else
    assign w_flush = 1'b0;
`endif

    // NOTE: the accumulator and output word are reset together with the
    // control flops, so no stale lane can leak into the first word after reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_close) begin
                r_data  <= w_merged;
                r_keep  <= w_keep_close;
                r_last  <= i_last;
                r_valid <= 1'b1;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_acc <= w_merged;
                r_cnt <= r_cnt + CW'(1);
            end else if (w_flush) begin
                r_data  <= r_acc;
                r_keep  <= w_keep_flush;
                r_last  <= 1'b0;
                r_valid <= 1'b1;
                r_acc   <= '0;
                r_cnt   <= '0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule

// File: tb/tb_cy_stream_packer.sv
// Scoreboard bench for cy_stream_packer (DW=8, RATIO=4): directed words, a
// random stream reassembled by a reference model, and the optional idle flush.
module tb_cy_stream_packer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic        i_last;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [3:0]  o_keep;
    logic        o_last;

    int          total = 0;
    int          bad   = 0;
    word_t       exp_q[$];
    bit          use_model  = 1'b0;
    bit          rand_ready = 1'b0;
    logic [31:0] m_acc  = '0;
    int          m_lane = 0;

    cy_stream_packer #(
        .DW      (8),
        .RATIO   (4),
        .TIMEOUT (16)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_keep    (o_keep),
        .o_last    (o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Reference reassembly of the random stream.
    task automatic model_accept(input logic [7:0] d, input logic l);
        m_acc[m_lane*8 +: 8] = d;
        if (l || m_lane == 3) begin
            push_exp(m_acc, 4'((1 << (m_lane + 1)) - 1), l);
            m_acc  = '0;
            m_lane = 0;
        end else begin
            m_lane++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int   n = 0;
        logic got;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        do begin
            #1;
            got = o_ready;
            @(posedge i_clk);
            #1;
            n++;
        end while (!got && n < 200);
        check("beat_accept_timeout", 64'(got), 64'(1));
        i_valid = 1'b0;
        i_last  = 1'b0;
        if (got && use_model) model_accept(d, l);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Monitor: every word transfer pops one expected word.
    initial begin
        word_t w;
        forever begin
            @(negedge i_clk);
            if (i_reset_n && o_valid && i_ready) begin
                check("word_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("word_data", 64'(o_data), 64'(w.data));
                    check("word_keep", 64'(o_keep), 64'(w.keep));
                    check("word_last", 64'(o_last), 64'(w.last));
                end
            end
        end
    end

    // Random downstream back-pressure when enabled.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_last    = 1'b0;
        i_ready   = 1'b1;
        idle(3);
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_data",  64'(o_data),  64'(0));
        check("rst_keep",  64'(o_keep),  64'(0));
        check("rst_last",  64'(o_last),  64'(0));
        i_reset_n = 1'b1;
        idle(1);
        check("rst_ready", 64'(o_ready), 64'(1));

        // Full word, then latency: o_valid right after the 4th beat's edge.
        push_exp(32'h44332211, 4'b1111, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        check("full_latency_valid", 64'(o_valid), 64'(1));

        // Early last, then the next word starts at lane 0.
        push_exp(32'h0000BBAA, 4'b0011, 1'b1);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        push_exp(32'hC4C3C2C1, 4'b1111, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        idle(2);

        // Back-pressure, then release together with a closing beat.
        i_ready = 1'b0;
        push_exp(32'h88776655, 4'b1111, 1'b0);
        push_exp(32'h00000099, 4'b0001, 1'b1);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        for (int s = 0; s < 5; s++) begin
            check("bp_ready", 64'(o_ready), 64'(0));
            check("bp_valid", 64'(o_valid), 64'(1));
            check("bp_data",  64'(o_data),  64'(32'h88776655));
            idle(1);
        end
        i_ready = 1'b1;
        send(8'h99, 1'b1);
        check("b2b_valid", 64'(o_valid), 64'(1));
        check("b2b_data",  64'(o_data),  64'(32'h00000099));
        idle(2);

        // Random stream reassembled by the model.
        use_model  = 1'b1;
        rand_ready = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            idle($urandom_range(0, 2));
            send(8'($urandom_range(0, 255)), (b == 999) || ($urandom_range(0, 4) == 0));
        end
        rand_ready = 1'b0;
        i_ready    = 1'b1;
        use_model  = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            idle(1);
            cyc++;
        end
        check("random_drain", 64'(exp_q.size()), 64'(0));

        // Reset mid-word discards the partial lanes.
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        i_reset_n = 1'b0;
        idle(1);
        i_reset_n = 1'b1;
        check("midrst_valid", 64'(o_valid), 64'(0));
        push_exp(32'h04030201, 4'b1111, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        idle(2);

`ifdef CY_PACK_TIMEOUT_EN
        // Single beat then idle: flushed word appears 16 cycles later.
        push_exp(32'h0000005A, 4'b0001, 1'b0);
        send(8'h5A, 1'b0);
        cyc = 0;
        while (!o_valid && cyc < 40) begin
            idle(1);
            cyc++;
        end
        check("timeout_latency", 64'(cyc), 64'(16));
        idle(2);
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
